// File: rtl/lcd_pkg.sv
// Shared definitions for the RGB565 LCD timing and pattern generator:
// pattern mode encodings, colour field widths and default 480x272 panel timing.
package lcd_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_SOLID = 2'd3
  } lcd_mode_e;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int RGB_W = R_W + G_W + B_W;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 50;
  localparam int DEF_H_SYNC   = 4;
  localparam int DEF_H_BP     = 26;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 20;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 3;
  localparam int DEF_CW       = 11;
  localparam int DEF_BARS     = 8;
  localparam int DEF_GRID     = 16;

endpackage

// File: rtl/lcd_pattern.sv
// Combinational test-pattern colour for one active-area pixel; blanking is
// applied by the caller, so this block only knows about visible coordinates.
module lcd_pattern
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int CW       = DEF_CW,
  parameter int BARS     = DEF_BARS,
  parameter int GRID     = DEF_GRID
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  lcd_mode_e     mode,
  input  rgb565_t       solid,
  output rgb565_t       rgb
);

  localparam int BAR_W = H_ACTIVE / BARS;
  localparam int GW    = CW + 7;

  logic [2:0]    bar_idx;
  logic [GW-1:0] x_ext;
  logic          on_grid;

  always_comb begin
    bar_idx = 3'(x / CW'(BAR_W));
    x_ext   = GW'(x);
    on_grid = ((x % CW'(GRID)) == '0) || ((y % CW'(GRID)) == '0) ||
              (x == CW'(H_ACTIVE - 1)) || (y == CW'(V_ACTIVE - 1));

    rgb = '0;
    case (mode)
      MODE_BARS: begin
        rgb.r = {R_W{bar_idx[2]}};
        rgb.g = {G_W{bar_idx[1]}};
        rgb.b = {B_W{bar_idx[0]}};
      end
      // Grey ramp: red/blue span 0..31 and green 0..63 across the line, truncating.
      MODE_GRAD: begin
        rgb.r = R_W'((x_ext << 5) / GW'(H_ACTIVE));
        rgb.g = G_W'((x_ext << 6) / GW'(H_ACTIVE));
        rgb.b = B_W'((x_ext << 5) / GW'(H_ACTIVE));
      end
      MODE_GRID:  rgb = on_grid ? '1 : '0;
      MODE_SOLID: rgb = solid;
      default:    rgb = '0;
    endcase
  end

endmodule

// File: rtl/lcd_sync_pattern_gen.sv
// Parallel RGB565 panel timing generator: h/v counters, HSYNC/VSYNC/DE decode,
// frame bookkeeping and a single aligned output register stage.
module lcd_sync_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CW       = DEF_CW,
  parameter int BARS     = DEF_BARS,
  parameter int GRID     = DEF_GRID
) (
  input  logic          PixelClk,
  input  logic          nRST,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [15:0]   solid_rgb,
  output logic          LCD_HSYNC,
  output logic          LCD_VSYNC,
  output logic          LCD_DE,
  output logic [4:0]    LCD_R,
  output logic [5:0]    LCD_G,
  output logic [4:0]    LCD_B,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_sof,
  output logic [7:0]    frame_cnt
);

  localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int V_ACT_START = V_SYNC + V_BP;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  lcd_mode_e     mode_q, mode_d;
  rgb565_t       colour_q, colour_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  rgb565_t       rgb_q, rgb_d;
  logic [CW-1:0] pix_x_q, pix_x_d;
  logic [CW-1:0] pix_y_q, pix_y_d;
  logic          sof_q, sof_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  logic          h_last, v_last, at_origin;
  logic          h_active, v_active;
  logic [CW-1:0] act_x, act_y;
  rgb565_t       pattern_rgb;

  lcd_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CW       (CW),
    .BARS     (BARS),
    .GRID     (GRID)
  ) u_pattern (
    .x     (act_x),
    .y     (act_y),
    .mode  (mode_q),
    .solid (colour_q),
    .rgb   (pattern_rgb)
  );

  always_comb begin
    h_last    = (h_cnt_q == CW'(H_TOTAL - 1));
    v_last    = (v_cnt_q == CW'(V_TOTAL - 1));
    at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    h_active  = (h_cnt_q >= CW'(H_ACT_START)) && (h_cnt_q < CW'(H_ACT_END));
    v_active  = (v_cnt_q >= CW'(V_ACT_START)) && (v_cnt_q < CW'(V_ACT_END));
    act_x     = h_cnt_q - CW'(H_ACT_START);
    act_y     = v_cnt_q - CW'(V_ACT_START);

    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + CW'(1);
      if (v_last) frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      h_cnt_d = h_cnt_q + CW'(1);
    end

    // Pattern selection only changes at the frame origin so a frame is never torn.
    mode_d   = at_origin ? lcd_mode_e'(mode) : mode_q;
    colour_d = at_origin ? rgb565_t'(solid_rgb) : colour_q;

    hsync_d = !(en && (h_cnt_q < CW'(H_SYNC)));
    vsync_d = !(en && (v_cnt_q < CW'(V_SYNC)));
    de_d    = en && h_active && v_active;
    rgb_d   = de_d ? pattern_rgb : '0;
    pix_x_d = de_d ? act_x : '0;
    pix_y_d = de_d ? act_y : '0;
    sof_d   = de_d && (act_x == '0) && (act_y == '0);
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      mode_q      <= MODE_BARS;
      colour_q    <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      de_q        <= 1'b0;
      rgb_q       <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      sof_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      mode_q      <= mode_d;
      colour_q    <= colour_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      rgb_q       <= rgb_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      sof_q       <= sof_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign LCD_HSYNC = hsync_q;
  assign LCD_VSYNC = vsync_q;
  assign LCD_DE    = de_q;
  assign LCD_R     = rgb_q.r;
  assign LCD_G     = rgb_q.g;
  assign LCD_B     = rgb_q.b;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign frame_sof = sof_q;
  assign frame_cnt = frame_cnt_q;

endmodule
